// File: rtl/lsu_split_if.sv
// Core-request and data-bus signal bundle for lsu_split.
// The slave modport is the load/store unit's view; master is the core/memory side.
interface lsu_split_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_func;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;

  logic [ADDR_W-1:0] bus_addr;
  logic [BYTES-1:0]  bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_dispatch_read;
  logic              bus_dispatch_write;
  logic              bus_busy;
  logic              bus_done;
  logic [DATA_W-1:0] bus_read_data;

  modport slave (
    input  req_valid, req_store, req_func, req_addr, req_wdata,
    input  bus_busy, bus_done, bus_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output bus_addr, bus_wstrb, bus_wdata, bus_dispatch_read, bus_dispatch_write
  );

  modport master (
    output req_valid, req_store, req_func, req_addr, req_wdata,
    output bus_busy, bus_done, bus_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  bus_addr, bus_wstrb, bus_wdata, bus_dispatch_read, bus_dispatch_write
  );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit: turns one core access into one or two aligned, byte-strobed bus beats
// and returns a lane-extracted, sign/zero-extended load value.
module lsu_split #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic        clk_in,
  input logic        rst_n_in,
  lsu_split_if.slave io
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SZ_W  = OFF_W + 2;
  localparam int SH_W  = OFF_W + 4;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
  state_t state_reg, state_next;

  logic              store_reg;
  logic              fault_reg;
  logic              cross_reg;
  logic [2:0]        func_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] word0_reg;
  logic [DATA_W-1:0] word1_reg;

  function automatic logic [SZ_W-1:0] size_of(input logic [2:0] func);
    return SZ_W'(1) << func[1:0];
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] func);
    return ((SZ_W+1)'(off) + (SZ_W+1)'(size_of(func))) > (SZ_W+1)'(BYTES);
  endfunction

  function automatic logic illegal(input logic [2:0] func);
    return (func == 3'd7) || ((DATA_W == 32) && ((func == 3'd3) || (func == 3'd6)));
  endfunction

  logic req_fault;
  assign req_fault = illegal(io.req_func) ||
                     (!SPLIT_MISALIGNED && crosses(io.req_addr[OFF_W-1:0], io.req_func));

  // Beat geometry derived from the latched request
  logic [OFF_W-1:0]  off;
  logic [OFF_W:0]    rev_off;
  logic [SZ_W-1:0]   size;
  logic [SH_W-1:0]   fwd_shift;
  logic [SH_W-1:0]   rev_shift;
  logic [ADDR_W-1:0] base_addr;
  logic [BYTES-1:0]  size_mask;
  logic [BYTES-1:0]  strb0;
  logic [BYTES-1:0]  strb1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  assign off       = addr_reg[OFF_W-1:0];
  assign rev_off   = (OFF_W+1)'(BYTES) - {1'b0, off};
  assign size      = size_of(func_reg);
  assign fwd_shift = SH_W'({off, 3'b000});
  assign rev_shift = {rev_off, 3'b000};
  assign base_addr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign strb0     = size_mask << off;
  assign strb1     = size_mask >> rev_off;
  assign wdata0    = wdata_reg << fwd_shift;
  assign wdata1    = wdata_reg >> rev_shift;

  // Load assembly: beat-0 upper lanes followed by beat-1 lower lanes; a shift of
  // DATA_W (off = 0) yields zero, so aligned loads take beat 0 alone.
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] load_ext;
  logic              sign;
  logic              fill;

  assign raw  = (word0_reg >> fwd_shift) | (word1_reg << rev_shift);
  assign fill = sign & ~func_reg[2];

  always_comb begin
    sign = raw[DATA_W-1];
    case (func_reg[1:0])
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[DATA_W-1];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign size_mask[gi]         = (SZ_W'(gi) < size);
      assign load_ext[8*gi +: 8]   = size_mask[gi] ? raw[8*gi +: 8] : {8{fill}};
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      store_reg <= 1'b0;
      fault_reg <= 1'b0;
      cross_reg <= 1'b0;
      func_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      word0_reg <= '0;
      word1_reg <= '0;
    end else begin
      if (state_reg == IDLE && io.req_valid) begin
        store_reg <= io.req_store;
        fault_reg <= req_fault;
        cross_reg <= crosses(io.req_addr[OFF_W-1:0], io.req_func);
        func_reg  <= io.req_func;
        addr_reg  <= io.req_addr;
        wdata_reg <= io.req_wdata;
      end
      if (state_reg == WAIT0 && io.bus_done) begin
        word0_reg <= io.bus_read_data;
      end
      if (state_reg == WAIT1 && io.bus_done) begin
        word1_reg <= io.bus_read_data;
      end
    end
  end

  always_comb begin
    state_next            = state_reg;
    io.req_ready          = 1'b0;
    io.resp_valid         = 1'b0;
    io.resp_rdata         = '0;
    io.resp_fault         = 1'b0;
    io.bus_addr           = '0;
    io.bus_wstrb          = '0;
    io.bus_wdata          = '0;
    io.bus_dispatch_read  = 1'b0;
    io.bus_dispatch_write = 1'b0;
    case (state_reg)
      IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) begin
          state_next = req_fault ? RESP : ISSUE0;
        end
      end
      ISSUE0: begin
        io.bus_addr  = base_addr;
        io.bus_wstrb = strb0;
        io.bus_wdata = wdata0;
        if (!io.bus_busy) begin
          io.bus_dispatch_read  = !store_reg;
          io.bus_dispatch_write = store_reg;
          state_next            = WAIT0;
        end
      end
      WAIT0: begin
        if (io.bus_done) begin
          state_next = cross_reg ? ISSUE1 : RESP;
        end
      end
      ISSUE1: begin
        io.bus_addr  = base_addr + ADDR_W'(BYTES);
        io.bus_wstrb = strb1;
        io.bus_wdata = wdata1;
        if (!io.bus_busy) begin
          io.bus_dispatch_read  = !store_reg;
          io.bus_dispatch_write = store_reg;
          state_next            = WAIT1;
        end
      end
      WAIT1: begin
        if (io.bus_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        io.resp_valid = 1'b1;
        io.resp_fault = fault_reg;
        io.resp_rdata = (store_reg || fault_reg) ? '0 : load_ext;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: one splitting instance and one faulting instance
// share clock and reset; each step checks outputs with immediate assertions.
module tb_lsu_split;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  lsu_split_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  lsu_split_if #(.DATA_W(32), .ADDR_W(32)) if_b ();

  lsu_split #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_split (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .io       (if_a)
  );

  lsu_split #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_nosplit (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .io       (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Aligned (single-beat) access on the splitting instance
  task automatic single(input string tag, input logic st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    chk({tag, "/ready"}, if_a.req_ready, 1);
    if_a.req_valid = 1'b1;
    if_a.req_store = st;
    if_a.req_func  = f;
    if_a.req_addr  = a;
    if_a.req_wdata = wd;
    tick();
    if_a.req_valid = 1'b0;
    chk({tag, "/ready_low"}, if_a.req_ready, 0);
    chk({tag, "/disp_rd"}, if_a.bus_dispatch_read, !st);
    chk({tag, "/disp_wr"}, if_a.bus_dispatch_write, st);
    chk({tag, "/addr"}, if_a.bus_addr, exp_addr);
    chk({tag, "/strb"}, if_a.bus_wstrb, exp_strb);
    chk({tag, "/wdata"}, if_a.bus_wdata, exp_wdata);
    tick();
    chk({tag, "/pulse_end"}, {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
    chk({tag, "/no_early_resp"}, if_a.resp_valid, 0);
    if_a.bus_done      = 1'b1;
    if_a.bus_read_data = word;
    tick();
    if_a.bus_done = 1'b0;
    chk({tag, "/resp_valid"}, if_a.resp_valid, 1);
    chk({tag, "/resp_fault"}, if_a.resp_fault, 0);
    chk({tag, "/resp_rdata"}, if_a.resp_rdata, exp_rdata);
    $display("txn %s addr=%h rdata=%h", tag, a, if_a.resp_rdata);
    tick();
    chk({tag, "/resp_end"}, if_a.resp_valid, 0);
    chk({tag, "/ready_back"}, if_a.req_ready, 1);
  endtask

  // Boundary-crossing access on the splitting instance
  task automatic split(input string tag, input logic st, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word0, input logic [31:0] word1,
                       input logic [31:0] addr0, input logic [3:0] strb0, input logic [31:0] wdata0,
                       input logic [31:0] addr1, input logic [3:0] strb1, input logic [31:0] wdata1,
                       input logic [31:0] exp_rdata);
    if_a.req_valid = 1'b1;
    if_a.req_store = st;
    if_a.req_func  = f;
    if_a.req_addr  = a;
    if_a.req_wdata = wd;
    tick();
    if_a.req_valid = 1'b0;
    chk({tag, "/b0_disp"}, {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, {!st, st});
    chk({tag, "/b0_addr"}, if_a.bus_addr, addr0);
    chk({tag, "/b0_strb"}, if_a.bus_wstrb, strb0);
    chk({tag, "/b0_wdata"}, if_a.bus_wdata, wdata0);
    tick();
    if_a.bus_done      = 1'b1;
    if_a.bus_read_data = word0;
    tick();
    if_a.bus_done = 1'b0;
    chk({tag, "/no_mid_resp"}, if_a.resp_valid, 0);
    chk({tag, "/b1_disp"}, {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, {!st, st});
    chk({tag, "/b1_addr"}, if_a.bus_addr, addr1);
    chk({tag, "/b1_strb"}, if_a.bus_wstrb, strb1);
    chk({tag, "/b1_wdata"}, if_a.bus_wdata, wdata1);
    tick();
    chk({tag, "/b1_pulse_end"}, {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
    if_a.bus_done      = 1'b1;
    if_a.bus_read_data = word1;
    tick();
    if_a.bus_done = 1'b0;
    chk({tag, "/resp_valid"}, if_a.resp_valid, 1);
    chk({tag, "/resp_fault"}, if_a.resp_fault, 0);
    chk({tag, "/resp_rdata"}, if_a.resp_rdata, exp_rdata);
    $display("txn %s addr=%h rdata=%h", tag, a, if_a.resp_rdata);
    tick();
    chk({tag, "/resp_end"}, if_a.resp_valid, 0);
  endtask

  // Faulting request: sel=1 targets the non-splitting instance
  task automatic fault(input string tag, input logic sel, input logic st,
                       input logic [2:0] f, input logic [31:0] a);
    if (sel) begin
      if_b.req_valid = 1'b1; if_b.req_store = st; if_b.req_func = f;
      if_b.req_addr  = a;    if_b.req_wdata = 32'h1122_3344;
    end else begin
      if_a.req_valid = 1'b1; if_a.req_store = st; if_a.req_func = f;
      if_a.req_addr  = a;    if_a.req_wdata = 32'h1122_3344;
    end
    tick();
    if_a.req_valid = 1'b0;
    if_b.req_valid = 1'b0;
    if (sel) begin
      chk({tag, "/resp_valid"}, if_b.resp_valid, 1);
      chk({tag, "/resp_fault"}, if_b.resp_fault, 1);
      chk({tag, "/no_disp"}, {if_b.bus_dispatch_read, if_b.bus_dispatch_write}, 0);
    end else begin
      chk({tag, "/resp_valid"}, if_a.resp_valid, 1);
      chk({tag, "/resp_fault"}, if_a.resp_fault, 1);
      chk({tag, "/no_disp"}, {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
    end
    $display("txn %s addr=%h fault response", tag, a);
    tick();
    chk({tag, "/after_disp"},
        {if_a.bus_dispatch_read, if_a.bus_dispatch_write, if_b.bus_dispatch_read, if_b.bus_dispatch_write}, 0);
    chk({tag, "/ready_back"}, {if_a.req_ready, if_b.req_ready}, 2'b11);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    if_a.req_valid = 1'b0; if_a.req_store = 1'b0; if_a.req_func = 3'd0;
    if_a.req_addr  = '0;   if_a.req_wdata = '0;
    if_a.bus_busy  = 1'b0; if_a.bus_done  = 1'b0; if_a.bus_read_data = '0;
    if_b.req_valid = 1'b0; if_b.req_store = 1'b0; if_b.req_func = 3'd0;
    if_b.req_addr  = '0;   if_b.req_wdata = '0;
    if_b.bus_busy  = 1'b0; if_b.bus_done  = 1'b0; if_b.bus_read_data = '0;
    #3;
    chk("reset/ready", if_a.req_ready, 1);
    chk("reset/resp", {if_a.resp_valid, if_a.resp_fault, if_a.resp_rdata}, 0);
    chk("reset/bus", {if_a.bus_addr, if_a.bus_wstrb, if_a.bus_wdata}, 0);
    chk("reset/disp", {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    single("lw_aligned", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF,
           32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF);
    single("lb_0x103", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234,
           32'h100, 4'h8, 32'h0, 32'hFFFF_FF80);
    single("lbu_0x103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234,
           32'h100, 4'h8, 32'h0, 32'h0000_0080);
    single("lh_0x102", 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_1234,
           32'h100, 4'hC, 32'h0, 32'hFFFF_80FF);
    single("lhu_0x102", 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_1234,
           32'h100, 4'hC, 32'h0, 32'h0000_80FF);
    single("lb_pos_0x101", 1'b0, 3'd0, 32'h101, 32'h0, 32'h80FF_1234,
           32'h100, 4'h2, 32'h0, 32'h0000_0012);
    single("sh_0x102", 1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 32'h0,
           32'h100, 4'hC, 32'hABCD_0000, 32'h0);

    split("sw_cross_0x0fe", 1'b1, 3'd2, 32'h0FE, 32'h1122_3344, 32'h0, 32'h0,
          32'h0FC, 4'hC, 32'h3344_0000, 32'h100, 4'h3, 32'h0000_1122, 32'h0);
    split("lw_cross_0x0fe", 1'b0, 3'd2, 32'h0FE, 32'h0, 32'h5566_7788, 32'h1122_3344,
          32'h0FC, 4'hC, 32'h0, 32'h100, 4'h3, 32'h0, 32'h3344_5566);
    split("lh_cross_0x1ff", 1'b0, 3'd1, 32'h1FF, 32'h0, 32'h9A00_0000, 32'h0000_00BC,
          32'h1FC, 4'h8, 32'h0, 32'h200, 4'h1, 32'h0, 32'hFFFF_BC9A);

    fault("sw_nosplit", 1'b1, 1'b1, 3'd2, 32'h0FE);
    fault("func7", 1'b0, 1'b0, 3'd7, 32'h100);
    fault("func3_rv32", 1'b0, 1'b0, 3'd3, 32'h100);

    // Slave busy for five cycles holds off the dispatch
    if_a.bus_busy  = 1'b1;
    if_a.req_valid = 1'b1; if_a.req_store = 1'b0; if_a.req_func = 3'd2;
    if_a.req_addr  = 32'h200;
    tick();
    if_a.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy/no_disp", {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
      if (i < 4) tick();
    end
    if_a.bus_busy = 1'b0;
    #1;
    chk("busy/disp_after_drop", if_a.bus_dispatch_read, 1);
    chk("busy/addr", if_a.bus_addr, 32'h200);
    tick();
    if_a.bus_done      = 1'b1;
    if_a.bus_read_data = 32'h1234_5678;
    tick();
    if_a.bus_done = 1'b0;
    chk("busy/resp_rdata", {if_a.resp_valid, if_a.resp_rdata}, {1'b1, 32'h1234_5678});
    $display("txn busy_lw addr=00000200 rdata=%h", if_a.resp_rdata);
    tick();

    // Reset while waiting for the bus; a stray done afterwards must be ignored
    if_a.req_valid = 1'b1; if_a.req_store = 1'b0; if_a.req_func = 3'd2;
    if_a.req_addr  = 32'h304;
    tick();
    if_a.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_wait0/ready", if_a.req_ready, 1);
    chk("rst_wait0/resp", {if_a.resp_valid, if_a.resp_fault, if_a.resp_rdata}, 0);
    chk("rst_wait0/bus", {if_a.bus_addr, if_a.bus_wstrb, if_a.bus_wdata}, 0);
    chk("rst_wait0/disp", {if_a.bus_dispatch_read, if_a.bus_dispatch_write}, 0);
    tick();
    rst_n = 1'b1;
    if_a.bus_done      = 1'b1;
    if_a.bus_read_data = 32'hCAFE_F00D;
    tick();
    if_a.bus_done = 1'b0;
    chk("rst_wait0/stray_done", if_a.resp_valid, 0);
    tick();
    chk("rst_wait0/stray_done2", {if_a.resp_valid, if_a.req_ready}, 2'b01);
    $display("txn reset_in_wait0 abandoned");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Parametrised load/store unit between the multi-cycle core's MEM/WRITEBACK stages and the data memory bus.
- Accepts one load or store per request and drives aligned, byte-strobed bus beats.
- Splits misaligned accesses that cross a bus-word boundary into two beats, or faults them, depending on a parameter.
- Performs lane extraction and sign/zero extension for loads, returning a full register value to the core.

Parameters:
- DATA_W, 32, register and bus data width; legal values 32 or 64. BYTES = DATA_W/8, OFF_W = log2(BYTES).
- ADDR_W, 32, byte-address width.
- SPLIT_MISALIGNED, 1. 1: split boundary-crossing accesses into two beats. 0: fault them with no bus traffic.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- req_valid  input  1  core request strobe
- req_ready  output  1  unit idle, can accept a request
- req_store  input  1  1 = store, 0 = load
- req_func  input  3  RISC-V funct3: 0 B, 1 H, 2 W, 3 D (DATA_W=64 only), 4 BU, 5 HU, 6 WU (DATA_W=64 only)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, LSB-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  DATA_W  extended load result; 0 for stores
- resp_fault  output  1  valid with resp_valid; illegal func, or misaligned with SPLIT_MISALIGNED=0
- bus_addr  output  ADDR_W  word-aligned address (low OFF_W bits 0)
- bus_wstrb  output  BYTES  byte enables for the beat
- bus_wdata  output  DATA_W  lane-shifted store data
- bus_dispatch_read  output  1  one-cycle read issue pulse
- bus_dispatch_write  output  1  one-cycle write issue pulse
- bus_busy  input  1  slave cannot accept a dispatch
- bus_done  input  1  one-cycle beat completion; bus_read_data valid this cycle
- bus_read_data  input  DATA_W  read word

Behaviour:
- Reset (async assert, sync release) drives outputs as follows: req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0; bus_dispatch_*=0; bus_addr=0, bus_wstrb=0, bus_wdata=0. State returns to IDLE.
- Reset mid-transaction abandons the transaction. Any later bus_done is ignored while in IDLE.
- Size: size = 1, 2, 4 or 8 bytes from req_func[1:0]; off = req_addr[OFF_W-1:0].
- Crossing condition: off + size > BYTES.
- Illegal func: func 7, or func 3/6 when DATA_W=32.
- FSM states and transitions:
  - IDLE: on req_valid, latch the request; req_ready falls the next cycle.
    - Illegal func, or crossing with SPLIT_MISALIGNED=0 -> RESP with fault.
    - Otherwise -> ISSUE0.
  - ISSUE0: when !bus_busy, pulse the dispatch (read or write) for exactly one cycle, with the beat-0 addr/wstrb/wdata valid the same cycle. -> WAIT0.
  - WAIT0: on bus_done, capture bus_read_data. Crossing -> ISSUE1, else -> RESP.
  - ISSUE1: beat 1 at address + BYTES, with the remaining bytes in lanes starting at 0. -> WAIT1 after dispatch.
  - WAIT1: on bus_done, capture the word. -> RESP.
  - RESP: resp_valid=1 for one cycle. -> IDLE, req_ready=1 the following cycle.
- Beat-0 strobes: bits [off .. min(off+size,BYTES)-1].
- Beat-1 strobes: bits [0 .. off+size-BYTES-1].
- Beat-0 wdata = req_wdata << 8*off. Beat-1 wdata = req_wdata >> 8*(BYTES-off). Unused lanes are don't-care but driven deterministically.
- Load assembly: take bytes from beat 0 lanes off..BYTES-1, then beat 1 lanes 0.., LSB first.
- Extension: sign-extend to DATA_W for funcs 0–3; zero-extend for funcs 4–6.
- Dispatch is never issued while bus_busy=1. bus_done arriving in the same cycle as dispatch is not legal slave behaviour; the unit ignores bus_done outside WAIT states.
- Latency, aligned, zero-wait slave: request accepted at T, dispatch T+1, bus_done T+2 (earliest), resp_valid T+3.
- Latency, crossing: adds 2 cycles plus slave latency.
- Fault response: resp_valid at T+1, no bus activity.
- Stores return resp_rdata=0.

Test Plan:
- Aligned LW, addr 0x100, bus returns 0xDEADBEEF at done -> one read dispatch at addr 0x100, wstrb 0xF; resp_rdata=0xDEADBEEF, fault=0, resp_valid 3 cycles after accept.
- LB at 0x103, word 0x80FF_1234 -> resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x102, wdata 0x0000ABCD -> single write at 0x100, wstrb 0xC, bus_wdata[31:16]=0xABCD.
- SW at 0x0FE, wdata 0x11223344, SPLIT_MISALIGNED=1:
  - beat 0: addr 0x0FC, wstrb 0xC, wdata[31:16]=0x3344;
  - beat 1: addr 0x100, wstrb 0x3, wdata[15:0]=0x1122;
  - one resp.
- Same SW with SPLIT_MISALIGNED=0 -> no dispatch, resp_fault=1 at T+1. Funct3=7 -> fault.
- Remaining control/reset cases:
  - hold bus_busy=1 for 5 cycles -> no dispatch until it drops;
  - assert rst_n_in low in WAIT0 -> all outputs at reset values immediately, req_ready=1, and a stray bus_done produces no resp.
